// File: rtl/dma_mc_engine_if.sv
// Memory-port bundle for the multi-channel DMA engine.
// master = engine side, slave = memory side (rdata valid one cycle after rd_en).
interface dma_mc_engine_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output rd_en, output wr_en, output addr, output wdata, input rdata);
  modport slave  (input rd_en, input wr_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/dma_mc_engine.sv
// Multi-channel memory-to-memory DMA: round-robin, one word per 4-cycle ARB/READ/CAPT/WRITE pass.
// Optional macro DMA_FIXED_ADDR_EN adds per-channel non-incrementing src/dst controls.
module dma_mc_engine #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
`ifdef DMA_FIXED_ADDR_EN
  input  logic              cfg_src_fix,
  input  logic              cfg_dst_fix,
`endif
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] ch_done,
  dma_mc_engine_if.master   bus
);

  localparam int unsigned       STEP     = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(STEP);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {ARB, READ, CAPT, WRITE} state_t;

  state_t            state;
  state_t            state_nx;

  logic [ADDR_W-1:0] src [NUM_CH];
  logic [ADDR_W-1:0] dst [NUM_CH];
  logic [LEN_W-1:0]  len [NUM_CH];
`ifdef DMA_FIXED_ADDR_EN
  logic [NUM_CH-1:0] src_fix;
  logic [NUM_CH-1:0] dst_fix;
`endif

  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   win_c;
  logic [CH_W-1:0]   rr_next_c;
  logic              win_vld_c;
  logic              cfg_ok_c;
  logic              last_word_c;
  logic              rd_en_nx;
  logic              wr_en_nx;
  logic [ADDR_W-1:0] src_inc_c;
  logic [ADDR_W-1:0] dst_inc_c;

  // A start is accepted only for an in-range, idle channel.
  always_comb begin
    cfg_ok_c = 1'b0;
    if (cfg_start && (32'(cfg_ch) < NUM_CH))
      cfg_ok_c = !ch_busy[cfg_ch];
  end

  // Round-robin search starting at rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_c     = '0;
    win_vld_c = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_CH;
      if (!win_vld_c && ch_busy[CH_W'(idx)]) begin
        win_vld_c = 1'b1;
        win_c     = CH_W'(idx);
      end
    end
  end

  assign rr_next_c   = (32'(win_c) == NUM_CH - 1) ? '0 : CH_W'(32'(win_c) + 1);
  assign last_word_c = (len[cur_ch] == LEN_ONE);

  // Post-word address update; fixed-port addresses stay put.
  always_comb begin
    src_inc_c = src[cur_ch] + ADDR_INC;
    dst_inc_c = dst[cur_ch] + ADDR_INC;
`ifdef DMA_FIXED_ADDR_EN
    if (src_fix[cur_ch]) src_inc_c = src[cur_ch];
    if (dst_fix[cur_ch]) dst_inc_c = dst[cur_ch];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en_nx = 1'b0;
    wr_en_nx = 1'b0;
    unique case (state)
      ARB: begin
        if (win_vld_c) begin
          state_nx = READ;
          rd_en_nx = 1'b1;
        end
      end
      READ:  state_nx = CAPT;
      CAPT: begin
        state_nx = WRITE;
        wr_en_nx = 1'b1;
      end
      WRITE: state_nx = ARB;
      default: state_nx = ARB;
    endcase
  end

  // Bus side: strobes, address and captured data are all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_en <= 1'b0;
      bus.wr_en <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      cur_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      bus.rd_en <= rd_en_nx;
      bus.wr_en <= wr_en_nx;
      if (state == ARB && win_vld_c) begin
        cur_ch   <= win_c;
        rr_ptr   <= rr_next_c;
        bus.addr <= src[win_c];
      end
      if (state == CAPT) begin
        bus.addr  <= dst[cur_ch];
        bus.wdata <= bus.rdata;
      end
    end
  end

  // Channel context: programming, per-word advance, completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_busy <= '0;
      ch_done <= '0;
      cfg_err <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        src[i] <= '0;
        dst[i] <= '0;
        len[i] <= '0;
      end
`ifdef DMA_FIXED_ADDR_EN
      src_fix <= '0;
      dst_fix <= '0;
`endif
    end else begin
      ch_done <= '0;
      cfg_err <= cfg_start && !cfg_ok_c;
      if (state == WRITE) begin
        src[cur_ch] <= src_inc_c;
        dst[cur_ch] <= dst_inc_c;
        len[cur_ch] <= len[cur_ch] - LEN_ONE;
        if (last_word_c) begin
          ch_busy[cur_ch] <= 1'b0;
          ch_done[cur_ch] <= 1'b1;
        end
      end
      if (cfg_ok_c) begin
        if (cfg_len == '0) begin
          ch_done[cfg_ch] <= 1'b1;
        end else begin
          src[cfg_ch]     <= cfg_src;
          dst[cfg_ch]     <= cfg_dst;
          len[cfg_ch]     <= cfg_len;
          ch_busy[cfg_ch] <= 1'b1;
`ifdef DMA_FIXED_ADDR_EN
          src_fix[cfg_ch] <= cfg_src_fix;
          dst_fix[cfg_ch] <= cfg_dst_fix;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_mc_engine.sv
// Self-checking bench for dma_mc_engine: directed corner cases plus randomized multi-channel traffic
// checked against a per-channel word-list model and an address-hash memory.
module tb_dma_mc_engine;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [ADDR_W-1:0] cfg_src = '0;
  logic [ADDR_W-1:0] cfg_dst = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
`ifdef DMA_FIXED_ADDR_EN
  logic              cfg_src_fix = 1'b0;
  logic              cfg_dst_fix = 1'b0;
`endif
  logic              cfg_err;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] ch_done;

  always #5 clk = ~clk;

  dma_mc_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dma_mc_engine #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_ch(cfg_ch),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
`ifdef DMA_FIXED_ADDR_EN
    .cfg_src_fix(cfg_src_fix), .cfg_dst_fix(cfg_dst_fix),
`endif
    .cfg_err(cfg_err), .ch_busy(ch_busy), .ch_done(ch_done), .bus(bus)
  );

  // Memory content is a fixed hash of the address; writes are only logged.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  // Read data valid exactly one cycle after rd_en; garbage otherwise.
  always @(posedge clk) bus.rdata <= bus.rd_en ? memf(bus.addr) : $urandom;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } ev_t;

  ev_t rd_log[$];
  ev_t wr_log[$];
  ev_t done_log[$];
  int  cyc = 0;
  int  both_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    e.c = cyc;
    e.d = bus.wdata;
    e.a = bus.addr;
    if (bus.rd_en) rd_log.push_back(e);
    if (bus.wr_en) wr_log.push_back(e);
    if (bus.rd_en && bus.wr_en) both_cnt++;
    if (ch_done != '0) begin
      e.a = 32'(ch_done);
      done_log.push_back(e);
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cfg_start strobe; returns 1ns after the edge that sampled it.
  task automatic start_ch(input int ch, input logic [31:0] s, input logic [31:0] d, input int l);
    cfg_start = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_src   = s;
    cfg_dst   = d;
    cfg_len   = LEN_W'(l);
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (ch_busy != '0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(ch_busy != '0), 64'd0);
    repeat (2) tick();
  endtask

  // Compares a channel's bus traffic (filtered by address tag nibble, ch<0 = no filter) with its word list.
  task automatic check_chan(input string nm, input int ch, input int rb, input int wb,
                            input logic [31:0] s, input logic [31:0] d, input int l,
                            input bit sinc, input bit dinc, output int last_wr);
    int k;
    logic [31:0] ea;
    last_wr = -1;
    k = 0;
    for (int i = rb; i < rd_log.size(); i++) begin
      if (ch < 0 || rd_log[i].a[31:28] == 4'(ch)) begin
        ea = s + (sinc ? 32'(4 * k) : 32'd0);
        check({nm, "_rd_addr"}, 64'(rd_log[i].a), 64'(ea));
        k++;
      end
    end
    check({nm, "_rd_cnt"}, 64'(k), 64'(l));
    k = 0;
    for (int i = wb; i < wr_log.size(); i++) begin
      if (ch < 0 || wr_log[i].a[31:28] == 4'(ch)) begin
        ea = d + (dinc ? 32'(4 * k) : 32'd0);
        check({nm, "_wr_addr"}, 64'(wr_log[i].a), 64'(ea));
        ea = s + (sinc ? 32'(4 * k) : 32'd0);
        check({nm, "_wr_data"}, 64'(wr_log[i].d), 64'(memf(ea)));
        last_wr = wr_log[i].c;
        k++;
      end
    end
    check({nm, "_wr_cnt"}, 64'(k), 64'(l));
  endtask

  task automatic done_info(input int db, input int ch, output int cnt, output int at);
    cnt = 0;
    at  = -1;
    for (int i = db; i < done_log.size(); i++) begin
      if (((done_log[i].a >> ch) & 32'd1) != 32'd0) begin
        cnt++;
        at = done_log[i].c;
      end
    end
  endtask

  logic [31:0] r_src [NUM_CH];
  logic [31:0] r_dst [NUM_CH];
  int          r_len [NUM_CH];
  bit          r_on  [NUM_CH];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, wb, db, lw, lw2, cnt, at, at2, sc, c;
    int ord [4];
    ord = '{0, 2, 0, 2};

    repeat (3) tick();
    check("rst_rd_en", 64'(bus.rd_en), 64'd0);
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_busy", 64'(ch_busy), 64'd0);
    check("rst_done", 64'(ch_done), 64'd0);
    check("rst_err", 64'(cfg_err), 64'd0);
    rst = 1'b0;
    tick();

    // Single channel, three words, exact timing.
    rb = rd_log.size(); wb = wr_log.size(); db = done_log.size();
    start_ch(0, 32'h0000_0100, 32'h0000_0200, 3);
    sc = cyc;
    check("t1_busy", 64'(ch_busy), 64'h1);
    wait_idle("t1_timeout", 100);
    check_chan("t1", 0, rb, wb, 32'h100, 32'h200, 3, 1'b1, 1'b1, lw);
    check("t1_first_rd_cyc", 64'(rd_log.size() > rb ? rd_log[rb].c - sc : -1), 64'd1);
    done_info(db, 0, cnt, at);
    check("t1_done_cnt", 64'(cnt), 64'd1);
    check("t1_done_cyc", 64'(at - sc), 64'd12);

    // Two channels interleave word by word.
    rb = rd_log.size(); wb = wr_log.size(); db = done_log.size();
    start_ch(0, 32'h0000_0300, 32'h0000_0400, 2);
    start_ch(2, 32'h2010_0000, 32'h2020_0000, 2);
    wait_idle("t2_timeout", 100);
    check("t2_wr_total", 64'(wr_log.size() - wb), 64'd4);
    if (wr_log.size() - wb >= 4) begin
      for (int i = 0; i < 4; i++)
        check("t2_rr_order", 64'(wr_log[wb + i].a[31:28]), 64'(ord[i]));
      check("t2_wr_spacing", 64'(wr_log[wb + 3].c - wr_log[wb].c), 64'd12);
    end
    check_chan("t2_ch0", 0, rb, wb, 32'h300, 32'h400, 2, 1'b1, 1'b1, lw);
    check_chan("t2_ch2", 2, rb, wb, 32'h2010_0000, 32'h2020_0000, 2, 1'b1, 1'b1, lw);
    done_info(db, 0, cnt, at);
    check("t2_done0_cnt", 64'(cnt), 64'd1);
    done_info(db, 2, cnt, at2);
    check("t2_done2_cnt", 64'(cnt), 64'd1);
    check("t2_ch0_first", 64'(at < at2), 64'd1);

    // Busy restart rejected; zero-length start completes at once.
    rb = rd_log.size(); wb = wr_log.size(); db = done_log.size();
    start_ch(1, 32'h1010_0000, 32'h1020_0000, 3);
    tick();
    start_ch(1, 32'h1AAA_0000, 32'h1BBB_0000, 5);
    check("t3_err_pulse", 64'(cfg_err), 64'd1);
    check("t3_busy_kept", 64'(ch_busy[1]), 64'd1);
    start_ch(3, 32'h3010_0000, 32'h3020_0000, 0);
    check("t3_err_clear", 64'(cfg_err), 64'd0);
    check("t3_len0_done", 64'(ch_done[3]), 64'd1);
    check("t3_len0_busy", 64'(ch_busy[3]), 64'd0);
    wait_idle("t3_timeout", 100);
    check_chan("t3_ch1", 1, rb, wb, 32'h1010_0000, 32'h1020_0000, 3, 1'b1, 1'b1, lw);
    check_chan("t3_ch3", 3, rb, wb, 32'h3010_0000, 32'h3020_0000, 0, 1'b1, 1'b1, lw);
    done_info(db, 3, cnt, at);
    check("t3_len0_done_cnt", 64'(cnt), 64'd1);

    // Start aimed at a channel in its completing cycle is rejected.
    db = done_log.size();
    start_ch(2, 32'h2030_0000, 32'h2040_0000, 1);
    repeat (3) tick();
    start_ch(2, 32'h2050_0000, 32'h2060_0000, 1);
    check("t4_err_on_complete", 64'(cfg_err), 64'd1);
    check("t4_done_same", 64'(ch_done[2]), 64'd1);
    check("t4_busy_clear", 64'(ch_busy[2]), 64'd0);
    wait_idle("t4_timeout", 50);
    done_info(db, 2, cnt, at);
    check("t4_done_cnt", 64'(cnt), 64'd1);

    // Source address wraps silently.
    rb = rd_log.size(); wb = wr_log.size();
    start_ch(1, 32'hFFFF_FFFC, 32'h1020_0000, 2);
    wait_idle("t5_timeout", 50);
    check_chan("t5_wrap", -1, rb, wb, 32'hFFFF_FFFC, 32'h1020_0000, 2, 1'b1, 1'b1, lw);

`ifdef DMA_FIXED_ADDR_EN
    // Fixed destination port.
    rb = rd_log.size(); wb = wr_log.size();
    cfg_dst_fix = 1'b1;
    start_ch(0, 32'h0000_0500, 32'h0000_0040, 4);
    cfg_dst_fix = 1'b0;
    wait_idle("t6_timeout", 50);
    check_chan("t6_fix", 0, rb, wb, 32'h500, 32'h40, 4, 1'b1, 1'b0, lw);
`endif

    // Randomized multi-channel traffic.
    for (int it = 0; it < 16; it++) begin
      rb = rd_log.size(); wb = wr_log.size(); db = done_log.size();
      for (int k = 0; k < NUM_CH; k++) begin
        r_on[k]  = (k == it % NUM_CH) || ($urandom_range(0, 1) == 1);
        r_len[k] = int'($urandom_range(0, 6));
        r_src[k] = {4'(k), 4'h1, 4'h0, 18'($urandom), 2'b00};
        r_dst[k] = {4'(k), 4'h2, 4'h0, 18'($urandom), 2'b00};
      end
      for (int j = 0; j < NUM_CH; j++) begin
        c = (it + j) % NUM_CH;
        if (r_on[c]) begin
          start_ch(c, r_src[c], r_dst[c], r_len[c]);
          check("rnd_cfg_err", 64'(cfg_err), 64'd0);
          if (r_len[c] == 0) begin
            check("rnd_len0_done", 64'(ch_done[c]), 64'd1);
            check("rnd_len0_busy", 64'(ch_busy[c]), 64'd0);
          end else begin
            check("rnd_busy", 64'(ch_busy[c]), 64'd1);
          end
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      wait_idle("rnd_timeout", 500);
      for (int k = 0; k < NUM_CH; k++) begin
        check_chan("rnd", k, rb, wb, r_src[k], r_dst[k], r_on[k] ? r_len[k] : 0, 1'b1, 1'b1, lw2);
        done_info(db, k, cnt, at);
        check("rnd_done_cnt", 64'(cnt), r_on[k] ? 64'd1 : 64'd0);
        if (r_on[k] && r_len[k] > 0)
          check("rnd_done_after_wr", 64'(at == lw2 + 1), 64'd1);
      end
    end

    // Reset mid-transfer aborts everything silently.
    start_ch(0, 32'h0000_1000, 32'h0000_2000, 8);
    repeat (6) tick();
    db = done_log.size();
    rst = 1'b1;
    tick();
    check("rstm_rd_en", 64'(bus.rd_en), 64'd0);
    check("rstm_wr_en", 64'(bus.wr_en), 64'd0);
    check("rstm_addr", 64'(bus.addr), 64'd0);
    check("rstm_wdata", 64'(bus.wdata), 64'd0);
    check("rstm_busy", 64'(ch_busy), 64'd0);
    check("rstm_done", 64'(ch_done), 64'd0);
    check("rstm_err", 64'(cfg_err), 64'd0);
    tick();
    rst = 1'b0;
    rb = rd_log.size(); wb = wr_log.size();
    repeat (20) tick();
    check("rstm_no_rd", 64'(rd_log.size() - rb), 64'd0);
    check("rstm_no_wr", 64'(wr_log.size() - wb), 64'd0);
    check("rstm_no_done", 64'(done_log.size() - db), 64'd0);

    check("rd_wr_exclusive", 64'(both_cnt), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
